apb_rr_master_arbiter: RTL and testbench

- Shares one APB master port between NREQ on-chip requesters. Typical requesters are the AHB bridge write path, a DMA and a debug port.
- Arbitrates round-robin, latches the winner's command, and sequences the APB SETUP/ACCESS phases, including pready wait states.
- Aborts hung transfers with an error after a timeout.
- Sits between the requester fabric and the APB peripheral decoder.

---
 rtl/apb_rr_master_arbiter.sv | 134 +++++++++++++
 tb/tb_apb_rr_master_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NREQ requesters.
// It latches the winner's command, runs SETUP/ACCESS and aborts hung transfers.
module apb_rr_master_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    output logic               pwrite,
    output logic               psel,
    output logic               penable,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   win;
    logic            win_valid;
    logic [IW-1:0]   cand;
    logic [CW-1:0]   cnt;
    logic            timeout_hit;

    // Search upward from the slot after the last winner, wrapping around.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!win_valid && req[cand]) begin
                win       = cand;
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        psel        = 1'b0;
        penable     = 1'b0;
        done        = '0;
        rdata       = '0;
        err         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel        = 1'b1;
                penable     = 1'b1;
                timeout_hit = (TIMEOUT != 0) && !pready && (cnt == CW'(TIMEOUT - 1));
                if (pready) begin
                    done      = gnt;
                    rdata     = pwrite ? '0 : prdata;
                    err       = pslverr;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    // Abort: report an error with no data
                    done      = gnt;
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state  <= IDLE;
            gnt    <= '0;
            paddr  <= '0;
            pwdata <= '0;
            pwrite <= 1'b0;
            last   <= IW'(NREQ - 1);
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        paddr  <= req_addr[win*AW +: AW];
                        pwdata <= req_wdata[win*DW +: DW];
                        pwrite <= req_write[win];
                        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        last   <= win;
                    end
                end
                SETUP: begin
                    cnt <= '0;
                end
                ACCESS: begin
                    if (state_nxt == IDLE) begin
                        gnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter: a scoreboard holds the expected
// completions and a monitor checks each done pulse against the queue head.
module tb_apb_rr_master_arbiter;

    typedef struct {
        logic [3:0]  done;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
    } exp_t;

    logic         hclk = 1'b0;
    logic         hreset;
    logic [3:0]   req;
    logic [3:0]   req_write;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [31:0]  rdata;
    logic         err;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic         pwrite;
    logic         psel;
    logic         penable;
    logic [31:0]  prdata  = '0;
    logic         pready  = 1'b0;
    logic         pslverr = 1'b0;

    int           slv_wait        = 0;
    logic         slv_setup_ready = 1'b0;
    logic [31:0]  slv_rdata       = '0;
    logic         slv_err         = 1'b0;
    int           acc_cnt         = 0;

    int           n_assert = 0;
    int           n_fail   = 0;
    exp_t         sb[$];

    always #5 hclk = ~hclk;

    apb_rr_master_arbiter #(
        .NREQ(4), .AW(32), .DW(32), .TIMEOUT(16)
    ) dut (
        .hclk(hclk), .hreset(hreset),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_write[idx]          = wr;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = wdata;
        req[idx]                = 1'b1;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] rd, input logic e,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
        exp_t x;
        x.done   = 4'b0001 << idx;
        x.rdata  = rd;
        x.err    = e;
        x.paddr  = addr;
        x.pwdata = wdata;
        x.pwrite = wr;
        sb.push_back(x);
    endtask

    // Waits for the next completion, checks who finished, then drops that req.
    task automatic wait_any_done(input int budget, input int exp_idx, input string tag);
        int cyc = 0;
        bit got = 1'b0;
        int idx = -1;
        while (!got && cyc < budget) begin
            @(negedge hclk);
            cyc++;
            if (|done) begin
                got = 1'b1;
                for (int i = 0; i < 4; i++) if (done[i]) idx = i;
            end
        end
        checkOutput({tag, "_idx"}, 64'(idx), 64'(exp_idx));
        if (got) begin
            @(posedge hclk);
            #1;
            req[idx] = 1'b0;
        end
    endtask

    // APB slave: ACCESS cycle n sees pready once n exceeds slv_wait (-1 = never).
    always @(posedge hclk) begin
        #1;
        if (psel && penable) acc_cnt = acc_cnt + 1;
        else                 acc_cnt = 0;
        pready  = (psel && penable) ? (slv_wait >= 0 && acc_cnt > slv_wait) : slv_setup_ready;
        prdata  = slv_rdata;
        pslverr = slv_err;
    end

    always @(negedge hclk) begin : monitor
        exp_t e;
        if (|done) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_done",   64'(done),   64'(e.done));
                checkOutput("sb_rdata",  64'(rdata),  64'(e.rdata));
                checkOutput("sb_err",    64'(err),    64'(e.err));
                checkOutput("sb_paddr",  64'(paddr),  64'(e.paddr));
                checkOutput("sb_pwdata", 64'(pwdata), 64'(e.pwdata));
                checkOutput("sb_pwrite", 64'(pwrite), 64'(e.pwrite));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int order[6];
        int acc;
        bit got;
        order = '{0, 1, 2, 3, 0, 3};
        hreset    = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        repeat (2) @(posedge hclk);
        @(negedge hclk);
        checkOutput("rst_psel",    64'(psel),    64'd0);
        checkOutput("rst_penable", 64'(penable), 64'd0);
        checkOutput("rst_gnt",     64'(gnt),     64'd0);
        checkOutput("rst_paddr",   64'(paddr),   64'd0);
        checkOutput("rst_pwdata",  64'(pwdata),  64'd0);
        checkOutput("rst_pwrite",  64'(pwrite),  64'd0);
        checkOutput("rst_done",    64'(done),    64'd0);
        checkOutput("rst_rdata",   64'(rdata),   64'd0);
        checkOutput("rst_err",     64'(err),     64'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        // Single read with zero wait states
        $display("[TB] single read");
        slv_wait  = 0;
        slv_rdata = 32'hDEADBEEF;
        applyStimulus(0, 1'b0, 32'h40, 32'h0);
        push_exp(0, 32'hDEADBEEF, 1'b0, 32'h40, 32'h0, 1'b0);
        @(negedge hclk);
        checkOutput("t1_psel_idle", 64'(psel), 64'd0);
        @(negedge hclk);
        checkOutput("t1_psel_setup",    64'(psel),    64'd1);
        checkOutput("t1_penable_setup", 64'(penable), 64'd0);
        checkOutput("t1_gnt",           64'(gnt),     64'b0001);
        @(negedge hclk);
        checkOutput("t1_penable_access", 64'(penable), 64'd1);
        checkOutput("t1_done",           64'(done),    64'b0001);
        @(posedge hclk);
        #1;
        req[0] = 1'b0;
        @(negedge hclk);
        checkOutput("t1_psel_after", 64'(psel), 64'd0);
        checkOutput("t1_gnt_after",  64'(gnt),  64'd0);
        @(posedge hclk);
        #1;

        // Write with three wait states; command fields change after grant
        $display("[TB] write with wait states");
        slv_wait        = 3;
        slv_rdata       = 32'hCAFEF00D;
        slv_setup_ready = 1'b1;
        applyStimulus(2, 1'b1, 32'h1000, 32'h12345678);
        push_exp(2, 32'h0, 1'b0, 32'h1000, 32'h12345678, 1'b1);
        @(negedge hclk);
        @(posedge hclk);
        #1;
        req_addr[2*32 +: 32]  = 32'hFFFF0000;
        req_wdata[2*32 +: 32] = 32'h0;
        @(negedge hclk);
        checkOutput("t2_setup_done",    64'(done),    64'd0);
        checkOutput("t2_setup_penable", 64'(penable), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge hclk);
            checkOutput("t2_paddr",  64'(paddr),  64'h1000);
            checkOutput("t2_pwdata", 64'(pwdata), 64'h12345678);
            checkOutput("t2_done",   64'(done),   (k == 4) ? 64'b0100 : 64'd0);
        end
        @(posedge hclk);
        #1;
        req[2]          = 1'b0;
        slv_setup_ready = 1'b0;

        // Round-robin fairness from a fresh reset
        $display("[TB] round robin");
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        hreset    = 1'b0;
        slv_wait  = 0;
        slv_rdata = 32'h1111;
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 32'(i * 256), 32'hA0 + 32'(i));
        for (int n = 0; n < 6; n++)
            push_exp(order[n], 32'h0, 1'b0, 32'(order[n] * 256), 32'hA0 + 32'(order[n]), 1'b1);
        for (int n = 0; n < 6; n++) begin
            wait_any_done(8, order[n], "t3_rr");
            if (n < 2) begin
                @(posedge hclk);
                #1;
                req[order[n]] = 1'b1;
            end else if (n == 2) begin
                @(posedge hclk);
                #1;
                req = 4'b1001;
            end else if (n == 3) begin
                @(posedge hclk);
                #1;
                req[3] = 1'b1;
            end
        end

        // Timeout abort with pready stuck low
        $display("[TB] timeout");
        slv_wait  = -1;
        slv_rdata = 32'h55AA55AA;
        applyStimulus(1, 1'b0, 32'h2000, 32'h0);
        push_exp(1, 32'h0, 1'b1, 32'h2000, 32'h0, 1'b0);
        @(negedge hclk);
        @(negedge hclk);
        acc = 0;
        got = 1'b0;
        while (!got && acc < 20) begin
            @(negedge hclk);
            acc++;
            if (done[1]) got = 1'b1;
        end
        checkOutput("t4_timeout_cycle", 64'(acc), 64'd16);
        @(posedge hclk);
        #1;
        req[1] = 1'b0;
        @(negedge hclk);
        checkOutput("t4_psel_after", 64'(psel), 64'd0);
        @(posedge hclk);
        #1;

        // Slave error reported with pready
        slv_wait  = 1;
        slv_err   = 1'b1;
        slv_rdata = 32'h77;
        applyStimulus(3, 1'b0, 32'h3000, 32'h0);
        push_exp(3, 32'h77, 1'b1, 32'h3000, 32'h0, 1'b0);
        wait_any_done(10, 3, "t4_slverr");
        slv_err = 1'b0;

        // Reset in the middle of a stalled write
        $display("[TB] reset mid-access");
        slv_wait  = -1;
        slv_rdata = 32'hBEEF0001;
        applyStimulus(2, 1'b1, 32'h4000, 32'hDEAD0002);
        repeat (4) @(negedge hclk);
        @(posedge hclk);
        #1;
        applyStimulus(1, 1'b0, 32'h5000, 32'h0);
        hreset = 1'b1;
        @(negedge hclk);
        checkOutput("t5_done_before", 64'(done), 64'd0);
        @(posedge hclk);
        #1;
        hreset   = 1'b0;
        slv_wait = 0;
        @(negedge hclk);
        checkOutput("t5_psel",    64'(psel),    64'd0);
        checkOutput("t5_penable", 64'(penable), 64'd0);
        checkOutput("t5_gnt",     64'(gnt),     64'd0);
        checkOutput("t5_done",    64'(done),    64'd0);
        push_exp(1, 32'hBEEF0001, 1'b0, 32'h5000, 32'h0, 1'b0);
        push_exp(2, 32'h0, 1'b0, 32'h4000, 32'hDEAD0002, 1'b1);
        wait_any_done(8, 1, "t5_first");
        wait_any_done(8, 2, "t5_second");

        repeat (2) @(negedge hclk);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
